fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_arb_pkg.sv | 7 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arb.sv | 82 ++++++++
 tb/tb_fifo_wr_arb.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: arbiter state encoding and default parameters shared by the FIFO write arbiter
package fifo_arb_pkg;
   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;
   localparam int DEF_DATA_SIZE = 8;
   localparam int DEF_NUM_REQ   = 4;
   localparam int DEF_MAX_BURST = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first asserted request at or after rr_ptr_i
module rr_pick #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      rr_ptr_i,
   output logic               found_o,
   output logic [IW-1:0]      idx_o
);
   localparam logic [IW:0] NR = (IW+1)'(NUM_REQ);
   logic [IW:0] pos;
   // scan from farthest to nearest so the nearest hit wins
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, rr_ptr_i} + (IW+1)'(k);
         pos = (pos >= NR) ? pos - NR : pos;
         if (req_i[pos[IW-1:0]]) begin
            found_o = 1'b1;
            idx_o   = pos[IW-1:0];
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter feeding the write side of an async FIFO
module fifo_wr_arb
   import fifo_arb_pkg::*;
#(
   parameter int DATA_SIZE = DEF_DATA_SIZE,
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int MAX_BURST = DEF_MAX_BURST,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = $clog2(MAX_BURST + 1)
) (
   input  logic                         wr_clk,
   input  logic                         wr_rstn,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
   output logic [NUM_REQ-1:0]           ack,
   input  logic                         wr_full,
   output logic                         wr_inc,
   output logic [DATA_SIZE-1:0]         wr_data,
   output logic                         owner_vld,
   output logic [IW-1:0]                owner_id
);
   localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);
   localparam logic [IW-1:0] TOP  = IW'(NUM_REQ - 1);
   arb_state_e state_q, state_d;
   logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic found, own_req;
   logic [DATA_SIZE-1:0] words [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
      assign words[g] = req_data[g*DATA_SIZE +: DATA_SIZE];
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .found_o  (found),
      .idx_o    (pick)
   );

   assign own_req   = req[owner_q];
   assign wr_inc    = (state_q == BURST) & own_req & ~wr_full;
   assign wr_data   = words[owner_q];
   assign ack       = wr_inc ? NUM_REQ'(1) << owner_q : '0;
   assign owner_vld = (state_q == BURST);
   assign owner_id  = owner_q;

   // a stall (full with request held) leaves everything untouched
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      rr_ptr_d = rr_ptr_q;
      if (state_q == IDLE) begin
         if (found) begin
            state_d = BURST;
            owner_d = pick;
            cnt_d   = '0;
         end
      end else begin
         if (wr_inc) cnt_d = cnt_q + 1'b1;
         if (!own_req || (wr_inc && cnt_q == LAST)) begin
            state_d  = IDLE;
            rr_ptr_d = (owner_q == TOP) ? '0 : owner_q + 1'b1;
         end
      end
   end

   always_ff @(posedge wr_clk or negedge wr_rstn) begin
      if (!wr_rstn) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed and randomized checks of fifo_wr_arb against a cycle-level behavioural model
module tb_fifo_wr_arb;
   localparam int N = 4, DW = 8, MB = 4;
   logic clk = 1'b0;
   logic wr_rstn, wr_full, wr_inc, owner_vld;
   logic [N-1:0] req, ack, ack_seen;
   logic [N*DW-1:0] req_data;
   logic [DW-1:0] wr_data;
   logic [1:0] owner_id;
   bit m_busy, prev_vld;
   int m_own, m_cnt, m_ptr, n_chk, n_fail;
   bit [63:0] hist;
   logic [DW-1:0] wq[$];
   logic [2:0] gq[$];

   fifo_wr_arb #(.DATA_SIZE(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
      .wr_clk(clk), .wr_rstn(wr_rstn), .req(req), .req_data(req_data), .ack(ack),
      .wr_full(wr_full), .wr_inc(wr_inc), .wr_data(wr_data),
      .owner_vld(owner_vld), .owner_id(owner_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic check_now();
      bit e_inc;
      e_inc = m_busy && req[m_own] && !wr_full;
      chk("wr_inc", wr_inc, e_inc);
      chk("ack", ack, e_inc ? (1 << m_own) : 0);
      chk("owner_vld", owner_vld, m_busy);
      if (m_busy) chk("owner_id", owner_id, m_own);
      if (e_inc) chk("wr_data", wr_data, req_data[m_own*DW +: DW]);
   endtask

   task automatic model_release();
      m_busy = 0;
      m_ptr  = (m_own + 1) % N;
   endtask

   task automatic model_update();
      bit hit;
      if (!wr_rstn) return;
      if (!m_busy) begin
         hit = 0;
         for (int k = 0; k < N; k++)
            if (!hit && req[(m_ptr + k) % N]) begin
               hit = 1;
               m_own = (m_ptr + k) % N;
            end
         if (hit) begin
            m_busy = 1;
            m_cnt  = 0;
         end
      end else if (!req[m_own]) model_release();
      else if (!wr_full) begin
         m_cnt++;
         if (m_cnt == MB) model_release();
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_own = 0; m_cnt = 0; m_ptr = 0;
   endtask

   task automatic cycle();
      @(negedge clk);
      check_now();
      hist = {hist[62:0], wr_inc};
      if (wr_inc) wq.push_back(wr_data);
      if (owner_vld && !prev_vld) gq.push_back({1'b0, owner_id});
      prev_vld = owner_vld;
      ack_seen = ack;
      @(posedge clk);
      model_update();
      #1;
      for (int i = 0; i < N; i++)
         if (ack_seen[i]) req_data[i*DW +: DW] = req_data[i*DW +: DW] + 1'b1;
   endtask

   task automatic do_reset();
      wr_rstn = 1'b0;
      model_reset();
      repeat (2) cycle();
      wr_rstn = 1'b1;
      hist = '0;
      wq.delete();
      gq.delete();
   endtask

   initial begin
      logic [31:0] words;
      int g;
      n_chk = 0; n_fail = 0; prev_vld = 0; hist = '0;
      wr_rstn = 1'b1; req = '0; wr_full = 1'b0; req_data = '0;
      model_reset();
      #2 wr_rstn = 1'b0;
      #1;
      chk("rst_wr_inc", wr_inc, 0);
      chk("rst_ack", ack, 0);
      chk("rst_owner_vld", owner_vld, 0);
      chk("rst_owner_id", owner_id, 0);
      // single requester: gap, 4 writes, gap, 4 writes
      do_reset();
      req = 4'b0001;
      repeat (10) cycle();
      chk("single_pattern", hist[9:0], 10'b0111101111);
      req = '0;
      cycle();
      // fairness with all requesting
      do_reset();
      req = 4'b1111;
      repeat (25) cycle();
      g = 0;
      foreach (gq[i]) g = g * 8 + int'(gq[i]);
      chk("fair_grants", gq.size(), 5);
      chk("fair_order", g, 15'o01230);
      chk("fair_writes", $countones(hist[24:0]), 20);
      req = '0;
      cycle();
      // backpressure on the second word
      do_reset();
      req_data[7:0] = 8'hA0;
      req = 4'b0001;
      repeat (2) cycle();
      wr_full = 1'b1;
      repeat (3) cycle();
      wr_full = 1'b0;
      repeat (4) cycle();
      chk("bp_pattern", hist[8:0], 9'b010001110);
      chk("bp_count", wq.size(), 4);
      words = (wq.size() == 4) ? {wq[0], wq[1], wq[2], wq[3]} : '0;
      chk("bp_order", words, 32'hA0A1A2A3);
      req = '0;
      cycle();
      // early release by owner 2, pointer moves to 3
      do_reset();
      req = 4'b1100;
      repeat (3) cycle();
      req = 4'b1001;
      repeat (2) cycle();
      chk("early_pattern", hist[4:0], 5'b01100);
      chk("early_vld", owner_vld, 1);
      chk("early_owner", owner_id, 3);
      req = '0;
      repeat (2) cycle();
      // async reset in the middle of owner 1's burst
      do_reset();
      req = 4'b0010;
      repeat (3) cycle();
      #2 wr_rstn = 1'b0;
      #1;
      model_reset();
      chk("midrst_wr_inc", wr_inc, 0);
      chk("midrst_ack", ack, 0);
      chk("midrst_vld", owner_vld, 0);
      chk("midrst_id", owner_id, 0);
      req = 4'b1111;
      repeat (2) cycle();
      wr_rstn = 1'b1;
      cycle();
      chk("postrst_vld", owner_vld, 1);
      chk("postrst_owner", owner_id, 0);
      // randomized traffic
      do_reset();
      req_data = {$urandom, $urandom} & {(N*DW){1'b1}};
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
         wr_full = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 599) == 0) do_reset();
         cycle();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
